// File: rtl/bpc_packet_deframer.sv
// rtl/bpc_packet_deframer.sv - reassembles fixed-length framed beats into one block for the decompressors
module bpc_packet_deframer #(
  parameter int D_BITWIDTH    = 64,
  parameter int BEATS         = 8,
  parameter int BCNT_BITWIDTH = $clog2(BEATS),
  parameter int ERR_BITWIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [D_BITWIDTH-1:0]         data_i,
  input  logic                          valid_i,
  input  logic                          sop_i,
  input  logic                          eop_i,
  input  logic [1:0]                    mode_i,
  output logic                          ready_o,
  output logic [D_BITWIDTH*BEATS-1:0]   block_o,
  output logic [1:0]                    mode_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          err_o,
  output logic [ERR_BITWIDTH-1:0]       err_cnt_o
);

  typedef enum logic {ST_IDLE, ST_COLLECT} state_e;

  state_e                            state_q, state_d;
  logic [BCNT_BITWIDTH-1:0]          bcnt_q, bcnt_d;
  logic [BEATS-1:0][D_BITWIDTH-1:0]  buf_q, buf_d, block_q;
  logic [1:0]                        amode_q, amode_d, mode_q;
  logic                              valid_q, valid_d;
  logic                              err_q, err_d;
  logic [ERR_BITWIDTH-1:0]           err_cnt_q;
  logic                              load;
  logic                              last_slot;
  logic                              accept;

  // Stall only the completing beat when the output register is still occupied.
  assign last_slot = (bcnt_q == BCNT_BITWIDTH'(BEATS-1));
  assign ready_o   = !(state_q == ST_COLLECT && last_slot && valid_q && !ready_i);
  assign accept    = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    buf_d   = buf_q;
    amode_d = amode_q;
    err_d   = 1'b0;
    load    = 1'b0;
    if (accept) begin
      if (state_q == ST_IDLE || sop_i) begin
        if (sop_i && mode_i != 2'b00) begin
          buf_d[0] = data_i;
          amode_d  = mode_i;
          bcnt_d   = BCNT_BITWIDTH'(1);
          state_d  = ST_COLLECT;
          err_d    = (state_q == ST_COLLECT);
        end else begin
          err_d   = 1'b1;
          bcnt_d  = '0;
          state_d = ST_IDLE;
        end
      end else if (!last_slot) begin
        if (eop_i) begin
          err_d   = 1'b1;
          bcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          buf_d[bcnt_q] = data_i;
          bcnt_d        = bcnt_q + 1'b1;
        end
      end else begin
        if (eop_i) begin
          buf_d[bcnt_q] = data_i;
          load          = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        bcnt_d  = '0;
        state_d = ST_IDLE;
      end
    end
    valid_d = load || (valid_q && !ready_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bcnt_q    <= '0;
      buf_q     <= '0;
      amode_q   <= 2'b00;
      block_q   <= '0;
      mode_q    <= 2'b00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      buf_q   <= buf_d;
      amode_q <= amode_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      if (load) begin
        block_q <= buf_d;
        mode_q  <= amode_q;
      end
      if (err_d && err_cnt_q != {ERR_BITWIDTH{1'b1}}) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign block_o   = block_q;
  assign mode_o    = mode_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_bpc_packet_deframer.sv
// tb/tb_bpc_packet_deframer.sv - randomized bench for bpc_packet_deframer against a packet-level model
module tb_bpc_packet_deframer;

  localparam int DW    = 64;
  localparam int BEATS = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW-1:0]     data_i = '0;
  logic              valid_i = 1'b0;
  logic              sop_i = 1'b0;
  logic              eop_i = 1'b0;
  logic [1:0]        mode_i = 2'b00;
  logic              ready_i = 1'b0;
  logic              ready_o, valid_o, err_o;
  logic [DW*BEATS-1:0] block_o;
  logic [1:0]        mode_o;
  logic [15:0]       err_cnt_o;
  logic              s_ready_o, s_valid_o, s_err_o;
  logic [DW*BEATS-1:0] s_block_o;
  logic [1:0]        s_mode_o;
  logic [2:0]        s_err_cnt_o;

  bpc_packet_deframer dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .sop_i(sop_i),
    .eop_i(eop_i), .mode_i(mode_i), .ready_o(ready_o), .block_o(block_o),
    .mode_o(mode_o), .valid_o(valid_o), .ready_i(ready_i), .err_o(err_o),
    .err_cnt_o(err_cnt_o)
  );

  bpc_packet_deframer #(.ERR_BITWIDTH(3)) dut_sat (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .sop_i(sop_i),
    .eop_i(eop_i), .mode_i(mode_i), .ready_o(s_ready_o), .block_o(s_block_o),
    .mode_o(s_mode_o), .valid_o(s_valid_o), .ready_i(ready_i), .err_o(s_err_o),
    .err_cnt_o(s_err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    bit            sop;
    bit            eop;
    logic [1:0]    m;
  } beat_t;

  beat_t stim_q[$];

  logic [DW-1:0]       m_coll[$];
  bit                  m_active;
  logic [1:0]          m_cmode;
  bit                  m_full;
  logic [DW*BEATS-1:0] m_blk;
  logic [1:0]          m_mode;
  bit                  m_err;
  bit                  m_ready;
  int                  m_cnt;
  int                  m_cnt_s;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [DW*BEATS-1:0] got, input logic [DW*BEATS-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_coll.delete();
    m_active = 0;
    m_cmode  = 2'b00;
    m_full   = 0;
    m_blk    = '0;
    m_mode   = 2'b00;
    m_err    = 0;
    m_cnt    = 0;
    m_cnt_s  = 0;
  endtask

  task automatic push_pkt(input int n, input int eop_idx, input logic [1:0] m,
                          input logic [DW-1:0] base, input bit with_sop);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d   = base + DW'(i);
      b.sop = with_sop && (i == 0);
      b.eop = (i == eop_idx);
      b.m   = (i == 0) ? m : 2'($urandom);
      stim_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    stim_q.delete();
    model_clear();
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_block_o", block_o, 0);
    chk("rst_mode_o", mode_o, 0);
    chk("rst_err_o", err_o, 0);
    chk("rst_err_cnt_o", err_cnt_o, 0);
    chk("rst_ready_o", ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input int vpct, input int rpct);
    bit acc, ld, e;
    @(negedge clk);
    chk("valid_o", valid_o, m_full);
    if (m_full) begin
      chk("block_o", block_o, m_blk);
      chk("mode_o", mode_o, m_mode);
    end
    chk("err_o", err_o, m_err);
    chk("err_cnt_o", err_cnt_o, m_cnt);
    chk("err_cnt_sat", s_err_cnt_o, m_cnt_s);
    if (stim_q.size() > 0 && $urandom_range(99) < vpct) begin
      valid_i = 1'b1;
      data_i  = stim_q[0].d;
      sop_i   = stim_q[0].sop;
      eop_i   = stim_q[0].eop;
      mode_i  = stim_q[0].m;
    end else begin
      valid_i = 1'b0;
      data_i  = {$urandom, $urandom};
      sop_i   = 1'($urandom);
      eop_i   = 1'($urandom);
      mode_i  = 2'($urandom);
    end
    ready_i = ($urandom_range(99) < rpct);
    #1;
    m_ready = !(m_active && m_coll.size() == BEATS-1 && m_full && !ready_i);
    chk("ready_o", ready_o, m_ready);
    @(posedge clk);
    acc = valid_i && m_ready;
    ld  = 0;
    e   = 0;
    if (acc) begin
      if (sop_i) begin
        if (m_active) e = 1;
        m_coll.delete();
        if (mode_i != 2'b00) begin
          m_coll.push_back(data_i);
          m_cmode  = mode_i;
          m_active = 1;
        end else begin
          m_active = 0;
          e = 1;
        end
      end else if (!m_active) begin
        e = 1;
      end else begin
        m_coll.push_back(data_i);
        if (m_coll.size() == BEATS && eop_i) begin
          ld = 1;
        end else if (m_coll.size() == BEATS || eop_i) begin
          e = 1;
          m_active = 0;
          m_coll.delete();
        end
      end
      stim_q.pop_front();
    end
    if (ld) begin
      for (int k = 0; k < BEATS; k++) m_blk[DW*k +: DW] = m_coll[k];
      m_mode   = m_cmode;
      m_full   = 1;
      m_active = 0;
      m_coll.delete();
    end else if (m_full && ready_i) begin
      m_full = 0;
    end
    m_err = e;
    if (e) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 7) m_cnt_s++;
    end
  endtask

  task automatic drain(input int vpct, input int rpct);
    int guard = 0;
    while (stim_q.size() > 0 && guard < 5000) begin
      step(vpct, rpct);
      guard++;
    end
    chk("drain_empty", stim_q.size(), 0);
    for (int i = 0; i < 4; i++) step(0, 100);
  endtask

  task automatic random_pkts(input int n);
    int kind, e;
    logic [1:0] m;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(9);
      m    = 2'($urandom_range(1, 3));
      case (kind)
        6: begin
          e = $urandom_range(1, 6);
          push_pkt(e + 1, e, m, {$urandom, $urandom}, 1);
        end
        7: push_pkt(BEATS, -1, m, {$urandom, $urandom}, 1);
        8: push_pkt($urandom_range(1, BEATS-1), -1, m, {$urandom, $urandom}, 1);
        9: begin
          if ($urandom_range(1)) push_pkt(BEATS, BEATS-1, 2'b00, {$urandom, $urandom}, 1);
          else push_pkt(1, $urandom_range(1) - 1, m, {$urandom, $urandom}, 0);
        end
        default: push_pkt(BEATS, BEATS-1, m, {$urandom, $urandom}, 1);
      endcase
    end
  endtask

  initial begin
    model_clear();
    do_reset();

    push_pkt(BEATS, BEATS-1, 2'b10, 64'h0, 1);
    drain(100, 100);
    chk("single_blk_lo", m_blk[63:0], 64'h0);
    chk("single_blk_hi", m_blk[511:448], 64'h7);
    chk("single_err_cnt", err_cnt_o, 0);

    do_reset();
    push_pkt(BEATS, BEATS-1, 2'b01, 64'h1000, 1);
    push_pkt(BEATS, BEATS-1, 2'b11, 64'h2000, 1);
    for (int i = 0; i < 20; i++) step(100, 0);
    chk("stall_pending", stim_q.size(), 1);
    chk("stall_ready_o", ready_o, 0);
    drain(100, 100);

    do_reset();
    push_pkt(5, 4, 2'b01, 64'h3000, 1);
    push_pkt(BEATS, BEATS-1, 2'b01, 64'h4000, 1);
    drain(100, 100);
    chk("early_eop_cnt", err_cnt_o, 1);

    do_reset();
    push_pkt(3, -1, 2'b01, 64'h5000, 1);
    push_pkt(BEATS, BEATS-1, 2'b11, 64'h6000, 1);
    drain(100, 100);
    chk("restart_cnt", err_cnt_o, 1);
    chk("restart_mode", mode_o, 2'b11);

    do_reset();
    push_pkt(BEATS, BEATS-1, 2'b00, 64'h7000, 1);
    drain(100, 100);
    chk("illegal_cnt", err_cnt_o, 8);
    chk("illegal_sat_cnt", s_err_cnt_o, 7);

    do_reset();
    push_pkt(BEATS, BEATS-1, 2'b10, 64'h8000, 1);
    for (int i = 0; i < 6; i++) step(100, 100);
    do_reset();
    push_pkt(BEATS, BEATS-1, 2'b01, 64'h9000, 1);
    drain(100, 100);
    chk("post_rst_cnt", err_cnt_o, 0);
    chk("post_rst_blk", m_blk[63:0], 64'h9000);

    do_reset();
    random_pkts(300);
    drain(70, 60);
    random_pkts(150);
    drain(100, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpc_packet_deframer.md
Name: bpc_packet_deframer

Overview:
- Receive side of the compressed-stream link; sits between the link input and the SR/ZRL/BPC decompressors.
- Accepts 64-bit beats framed by sop/eop, with a 2-bit mode sideband sampled on the sop beat.
- Reassembles exactly BEATS beats into one block and hands it downstream with a valid/ready handshake.
- Drops malformed packets and counts framing errors.

Parameters:
- D_BITWIDTH, 64, beat width in bits.
- BEATS, 8, beats per packet (fixed packet length).
- BCNT_BITWIDTH, $clog2(8), width of the beat counter.
- ERR_BITWIDTH, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- data_i  input  D_BITWIDTH  incoming beat.
- valid_i  input  1  beat valid.
- sop_i  input  1  first beat of packet.
- eop_i  input  1  last beat of packet.
- mode_i  input  2  01=SR, 10=ZRL, 11=BPC, 00=illegal; meaningful only with sop_i.
- ready_o  output  1  deframer can accept a beat this cycle.
- block_o  output  D_BITWIDTH*BEATS  assembled block; beat k occupies bits [64k+63:64k].
- mode_o  output  2  mode of block_o.
- valid_o  output  1  block_o/mode_o valid.
- ready_i  input  1  downstream accepts block.
- err_o  output  1  one-cycle pulse per dropped packet or stray beat.
- err_cnt_o  output  ERR_BITWIDTH  saturating count of err_o pulses.

Behaviour:
- Reset (async, rst=1): bcnt=0, state=IDLE, valid_o=0, block_o=0, mode_o=0, err_o=0, err_cnt_o=0, assembly buffer cleared. Reset mid-packet discards the partial packet; no error is counted.
- Beat accept: valid_i & ready_o at posedge. Block handoff: valid_o & ready_i at posedge.
- ready_o = !(state==COLLECT && bcnt==BEATS-1 && valid_o && !ready_i). Combinational path from ready_i is permitted. Otherwise ready_o=1.
- States:
  - IDLE: waiting for sop. An accepted beat with sop_i=1 and mode_i!=00 stores the beat in slot 0, latches mode, sets bcnt=1, goes to COLLECT.
  - IDLE, sop_i=1 and mode_i=00: discard, err pulse, stay IDLE.
  - IDLE, sop_i=0: discard, err pulse, stay IDLE.
  - COLLECT, beat with sop_i=1: the partial packet is dropped with an err pulse. The beat restarts assembly as slot 0 under the IDLE sop rules above; if mode_i=00, go to IDLE. Only one err pulse is issued for the cycle.
  - COLLECT, bcnt<BEATS-1: eop_i=1 -> drop, err pulse, IDLE. eop_i=0 -> store in slot bcnt, bcnt+1.
  - COLLECT, bcnt==BEATS-1: eop_i=0 -> drop, err pulse, IDLE. eop_i=1 -> store the beat, copy the full buffer and mode into block_o/mode_o, set valid_o=1 on the next cycle, bcnt=0, IDLE.
- Latency: valid_o rises 1 cycle after the accepted eop beat.
- Throughput: back-to-back packets run at 1 beat/cycle when ready_i=1.
- Output register: block_o/mode_o are held stable while valid_o=1 and ready_i=0.
- Simultaneous load and handoff: if the final beat is accepted in the same cycle as a handoff, the new block loads and valid_o stays 1.
- Handoff with no load: valid_o clears.
- bcnt wrap: never exceeds BEATS-1; returns to 0 on completion or drop.
- err_cnt_o increments by 1 per err pulse and saturates at all-ones.
- err_o is registered: high the cycle after the offending accept.
- A beat with valid_i=0 has no effect regardless of sop_i/eop_i.

Test Plan:
- Single packet, mode_i=10, beats 0x0..0x7 with sop on beat 0, eop on beat 7, ready_i=1 -> valid_o=1 for 1 cycle, 1 cycle after beat 7; block_o[63:0]=0, block_o[511:448]=7; mode_o=10; err_cnt_o=0.
- Two back-to-back packets with ready_i=0 until cycle 20 -> ready_o=0 while beat 7 of packet 2 is presented. Packet 1 block is held stable. Packet 2 is accepted in the handoff cycle, giving valid_o continuous for 2 blocks; no beats are lost.
- eop on beat 4 -> err_o pulse, err_cnt_o=1, no valid_o. A following good packet is delivered correctly.
- sop reasserted on beat 3 with mode_i=11 -> err_cnt_o=1; the new packet completes after 8 beats from the restart with mode_o=11.
- sop beat with mode_i=00 followed by 7 beats -> 8 err pulses total (1 for the sop beat, 7 for stray beats), err_cnt_o=8, no valid_o.
- rst asserted after beat 5, then a clean packet -> block_o holds only the new packet data; err_cnt_o=0.
- Additional check: force err_cnt_o to all-ones, inject an error -> err_cnt_o stays 0xFFFF.
